// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 7-segment display blocks:
// scan FSM states, the all-off segment pattern and decimal glyphs.
package seg7_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

  // Pin-level pattern with every segment dark (pins are active-low).
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Glyph patterns use bit=1 for a lit segment (bit0=a ... bit6=g, bit7=dp).
  localparam logic [7:0] GLYPH_0 = 8'h3F;
  localparam logic [7:0] GLYPH_1 = 8'h06;
  localparam logic [7:0] GLYPH_2 = 8'h5B;
  localparam logic [7:0] GLYPH_3 = 8'h4F;
  localparam logic [7:0] GLYPH_4 = 8'h66;
  localparam logic [7:0] GLYPH_5 = 8'h6D;
  localparam logic [7:0] GLYPH_6 = 8'h7D;
  localparam logic [7:0] GLYPH_7 = 8'h07;
  localparam logic [7:0] GLYPH_8 = 8'h7F;
  localparam logic [7:0] GLYPH_9 = 8'h6F;

  function automatic logic [7:0] seg7_glyph(input logic [3:0] digit);
    case (digit)
      4'd0:    return GLYPH_0;
      4'd1:    return GLYPH_1;
      4'd2:    return GLYPH_2;
      4'd3:    return GLYPH_3;
      4'd4:    return GLYPH_4;
      4'd5:    return GLYPH_5;
      4'd6:    return GLYPH_6;
      4'd7:    return GLYPH_7;
      4'd8:    return GLYPH_8;
      4'd9:    return GLYPH_9;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_slot.sv
// Digit-slot timer: counts TICK_DIV cycles per slot, flags the last
// blanking cycle and the last slot cycle. clear holds the count at zero.
module seg7_slot_timer #(
  parameter int TICK_DIV  = 50000,
  parameter int BLANK_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick,
  output logic blank_end
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  logic [CW-1:0] cnt;

  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge
  // values regardless of the order blocks are evaluated in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick      = (cnt == TICK_LAST);
  assign blank_end = (cnt == BLANK_LAST);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Scan scheduler for an N-digit multiplexed 7-segment display: blanking
// gap per slot, 4-bit PWM brightness, double-buffered frame write port.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int TICK_DIV  = 50000,
  parameter int BLANK_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [3:0]            bright,
  input  logic                  wr_valid,
  input  logic [DIGITS*8-1:0]   wr_data,
  output logic                  wr_ready,
  output logic                  frame_done,
  output logic [7:0]            seg_dat,
  output logic [DIGITS-1:0]     sel
);

  localparam int IW = $clog2(DIGITS);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  scan_state_e           state, state_next;
  logic [IW-1:0]         idx;
  logic [3:0]            pwm_cnt;
  logic [DIGITS*8-1:0]   active, pending;
  logic                  pend_full;
  logic                  tick, blank_end, timer_clear;
  logic                  boundary, accept;
  logic [7:0]            active_digit;

  assign timer_clear = (state == ST_IDLE) || !enable;

  seg7_slot_timer #(
    .TICK_DIV  (TICK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_slot_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (timer_clear),
    .tick      (tick),
    .blank_end (blank_end)
  );

  // NOTE: next state gets its default before the case so no path leaves it
  // unassigned; otherwise always_comb would imply a latch.
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_next = ST_BLANK;
        ST_BLANK: if (blank_end) state_next = ST_DRIVE;
        ST_DRIVE: if (tick)      state_next = ST_BLANK;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // A frame starts on leaving IDLE or when the last digit's slot wraps.
  assign boundary = enable &&
                    ((state == ST_IDLE) || (state == ST_DRIVE && tick && idx == IDX_LAST));
  assign accept   = wr_valid && !pend_full;
  assign wr_ready = ~pend_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      pwm_cnt <= '0;
    end else begin
      state <= state_next;
      if (!enable || state == ST_IDLE) begin
        idx <= '0;
      end else if (state == ST_DRIVE && tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end
      pwm_cnt <= (state == ST_DRIVE) ? pwm_cnt + 4'd1 : 4'd0;
    end
  end

  // NOTE: the frame buffers are plain registers and take reset, so a
  // display enabled after reset shows a known blank frame, never stale data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active     <= '0;
      pending    <= '0;
      pend_full  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (boundary && pend_full) begin
        active    <= pending;
        pend_full <= 1'b0;
      end
      // accept implies pend_full was clear, so it never collides with the copy.
      if (accept) begin
        pending   <= wr_data;
        pend_full <= 1'b1;
      end
    end
  end

  assign active_digit = active[8*idx +: 8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_dat <= SEG_OFF;
      sel     <= '1;
    end else if (state == ST_DRIVE) begin
      sel     <= ~(DIGITS'(1) << idx);
      seg_dat <= (pwm_cnt <= bright) ? ~active_digit : SEG_OFF;
    end else begin
      seg_dat <= SEG_OFF;
      sel     <= '1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a position-in-frame reference model
// predicts every output cycle; a monitor compares the DUT against it.
module tb_seg7_scan_ctrl;

  localparam int DIGITS    = 4;
  localparam int TICK_DIV  = 16;
  localparam int BLANK_CYC = 4;
  localparam int FRAME     = DIGITS * TICK_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  bright;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        frame_done;
  logic [7:0]  seg_dat;
  logic [3:0]  sel;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .DIGITS    (DIGITS),
    .TICK_DIV  (TICK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .bright     (bright),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .frame_done (frame_done),
    .seg_dat    (seg_dat),
    .sel        (sel)
  );

  typedef struct {
    logic [7:0] seg;
    logic [3:0] sel;
    logic       fd;
    logic       rdy;
    int         n;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: scan position counted in cycles since the frame began.
  bit         m_run;
  int         m_pos;
  logic [7:0] m_act  [DIGITS];
  logic [7:0] m_pend [DIGITS];
  bit         m_pfull;
  int         m_cyc = 0;
  bit         cur_en;
  logic [3:0] cur_br;

  task automatic model_reset();
    m_run   = 0;
    m_pos   = 0;
    m_pfull = 0;
    for (int k = 0; k < DIGITS; k++) begin
      m_act[k]  = 8'h00;
      m_pend[k] = 8'h00;
    end
  endtask

  task automatic model_step();
    exp_t       e;
    int         d, ph;
    bit         bnd, acc;
    logic [3:0] one_hot;
    logic [7:0] pat;
    e.seg = 8'hFF;
    e.sel = 4'hF;
    if (m_run && (m_pos % TICK_DIV) >= BLANK_CYC) begin
      d       = m_pos / TICK_DIV;
      ph      = ((m_pos % TICK_DIV) - BLANK_CYC) % 16;
      one_hot = 4'(1) << d;
      pat     = m_act[d];
      e.sel   = ~one_hot;
      e.seg   = (ph <= int'(bright)) ? ~pat : 8'hFF;
    end
    bnd = enable && (!m_run || m_pos == FRAME - 1);
    acc = wr_valid && !m_pfull;
    if (bnd && m_pfull) begin
      for (int k = 0; k < DIGITS; k++) m_act[k] = m_pend[k];
      m_pfull = 0;
    end
    if (acc) begin
      for (int k = 0; k < DIGITS; k++) m_pend[k] = wr_data[8*k +: 8];
      m_pfull = 1;
    end
    if (!enable) begin
      m_run = 0;
      m_pos = 0;
    end else if (!m_run) begin
      m_run = 1;
      m_pos = 0;
    end else begin
      m_pos = (m_pos + 1) % FRAME;
    end
    e.fd  = bnd;
    e.rdy = !m_pfull;
    e.n   = m_cyc;
    m_cyc++;
    q.push_back(e);
  endtask

  // Entered and left at a negative edge; exactly one modelled rising edge.
  task automatic cyc(input bit v, input logic [31:0] d);
    enable   = cur_en;
    bright   = cur_br;
    wr_valid = v;
    wr_data  = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0);
  endtask

  task automatic run_until(input int p);
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (m_run && m_pos == p) break;
      cyc(1'b0, 32'h0);
    end
    check("run_until_reached", 32'(m_run && m_pos == p), 32'd1);
  endtask

  task automatic write_word(input logic [31:0] d);
    bit done = 0;
    for (int i = 0; i < 4 * FRAME && !done; i++) begin
      done = !m_pfull;
      cyc(1'b1, d);
    end
    check("write_accepted", 32'(done), 32'd1);
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_seg_dat"},    seg_dat,    8'hFF);
    check({tag, "_sel"},        sel,        4'hF);
    check({tag, "_wr_ready"},   wr_ready,   1'b1);
    check({tag, "_frame_done"}, frame_done, 1'b0);
  endtask

  task automatic reset_phase(input int n);
    rst      = 1'b0;
    enable   = 1'b0;
    wr_valid = 1'b0;
    model_reset();
    #1;
    check_reset_pins("reset");
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_reset_pins("reset_hold");
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check($sformatf("seg_dat@%0d", e.n),    seg_dat,    e.seg);
        check($sformatf("sel@%0d", e.n),        sel,        e.sel);
        check($sformatf("frame_done@%0d", e.n), frame_done, e.fd);
        check($sformatf("wr_ready@%0d", e.n),   wr_ready,   e.rdy);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst      = 1'b0;
    enable   = 1'b0;
    bright   = 4'd0;
    wr_valid = 1'b0;
    wr_data  = '0;
    cur_en   = 1'b0;
    cur_br   = 4'd0;
    model_reset();
    @(negedge clk);
    reset_phase(4);

    // First frame loaded while idle, then shown at full brightness.
    write_word(32'h4F5B063F);
    cur_en = 1'b1;
    cur_br = 4'd15;
    run(2 * FRAME);

    // Backpressure: A accepted mid-frame, B held until A is applied.
    run_until(20);
    write_word(32'h6D664F5B);
    write_word(32'h077D6D66);
    run(2 * FRAME);

    cur_br = 4'd3;
    run(FRAME);

    // Enable dropped in slot 2, cycle 7; restart must begin at digit 0.
    cur_br = 4'd15;
    run_until(2 * TICK_DIV + 7);
    cur_en = 1'b0;
    run(5);
    cur_en = 1'b1;
    run(FRAME + 8);

    for (int i = 0; i < 1500; i++) begin
      if (cur_en) cur_en = ($urandom_range(0, 149) != 0);
      else        cur_en = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) cur_br = 4'($urandom_range(0, 15));
      cyc(($urandom_range(0, 24) == 0), $urandom);
    end

    // Reset mid-operation discards a pending write.
    cur_en = 1'b1;
    cur_br = 4'd15;
    run_until(30);
    write_word(32'h7F6F3F06);
    reset_phase(3);
    run(FRAME + 8);

    @(posedge clk);
    #2;
    check("scoreboard_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
